// File: rtl/spu_fetch_pkg.sv
// Shared types and constants for the SPU dual-issue fetch stage.
// A fetch_pair_t is one 64-bit local-store pair together with its address tags.
package spu_fetch_pkg;

  localparam int          LS_ADDR_W_DEF = 18;
  localparam int          PAIR_BYTES    = 8;
  localparam logic [31:0] BUBBLE_INSTR  = 32'h0;

  typedef struct packed {
    logic [31:0]              even;
    logic [31:0]              odd;
    logic [LS_ADDR_W_DEF-1:0] pc;
    logic                     odd_start;
  } fetch_pair_t;

  localparam fetch_pair_t BUBBLE_PAIR = '{
    even:      BUBBLE_INSTR,
    odd:       BUBBLE_INSTR,
    pc:        '0,
    odd_start: 1'b0
  };

  // Even word lives in the upper half of a local-store read.
  function automatic fetch_pair_t make_pair(input logic [63:0]              rdata,
                                            input logic [LS_ADDR_W_DEF-1:0] pc,
                                            input logic                     odd_start);
    fetch_pair_t p;
    p.even      = rdata[63:32];
    p.odd       = rdata[31:0];
    p.pc        = pc;
    p.odd_start = odd_start;
    return p;
  endfunction

endpackage

// File: rtl/spu_fetch_unit_hold.sv
// One-entry skid register: captures the returning pair when the stage stalls
// so the single-cycle local-store latency never loses data.
module fetch_hold_reg
  import spu_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_clear,
  input  fetch_pair_t i_data,
  output logic        o_valid,
  output fetch_pair_t o_data
);

  logic        r_valid;
  fetch_pair_t r_data;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)        r_valid <= 1'b0;
    else if (i_clear) r_valid <= 1'b0;
    else if (i_load)  r_valid <= 1'b1;
  end

  // NOTE: the payload has no reset; it is only observed while r_valid is set.
  always_ff @(posedge clk) begin
    if (i_load) r_data <= i_data;
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/spu_fetch_unit.sv
// Dual-issue fetch stage: owns the PC, issues one pair read per cycle and
// presents an even/odd instruction pair (or a bubble) to IF_ID every cycle.
module spu_fetch_unit
  import spu_fetch_pkg::*;
#(
  parameter int LS_ADDR_W = LS_ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [LS_ADDR_W-1:0] redirect_pc,
  output logic                 ls_rd_en,
  output logic [LS_ADDR_W-1:0] ls_addr,
  input  logic [63:0]          ls_rdata,
  output logic [31:0]          instruction1_IF,
  output logic [31:0]          instruction2_IF,
  output logic [LS_ADDR_W-1:0] pc_IF,
  output logic                 fetch_valid
);

  logic [LS_ADDR_W-1:0] r_pc;
  logic                 r_inflight;
  logic [LS_ADDR_W-1:0] r_ifl_pc;
  logic                 r_ifl_odd;

  logic [LS_ADDR_W-1:0] w_redirect_addr;
  logic                 w_hold_valid;
  logic                 w_hold_load;
  logic                 w_hold_clear;
  fetch_pair_t          w_ifl_pair;
  fetch_pair_t          w_hold_pair;
  fetch_pair_t          w_shown;
  logic                 w_shown_valid;
  logic                 w_unused_ok;

  // Word-select bits of the target are ignored; bit 2 only chooses the starting slot.
  assign w_redirect_addr = {redirect_pc[LS_ADDR_W-1:3], 3'b000};
  assign w_unused_ok     = &{1'b0, redirect_pc[1:0]};

  assign w_ifl_pair   = make_pair(ls_rdata, LS_ADDR_W_DEF'(r_ifl_pc), r_ifl_odd);
  assign w_hold_load  = !reset && !redirect && stall && r_inflight && !w_hold_valid;
  assign w_hold_clear = redirect || !stall;

  fetch_hold_reg u_hold (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_hold_load),
    .i_clear (w_hold_clear),
    .i_data  (w_ifl_pair),
    .o_valid (w_hold_valid),
    .o_data  (w_hold_pair)
  );

  // Request side: redirect overrides stall, and nothing is requested during reset.
  assign ls_rd_en = !reset && (redirect || !stall);
  assign ls_addr  = redirect ? w_redirect_addr : r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= '0;
      r_inflight <= 1'b0;
      r_ifl_pc   <= '0;
      r_ifl_odd  <= 1'b0;
    end else if (redirect) begin
      r_pc       <= w_redirect_addr + LS_ADDR_W'(PAIR_BYTES);
      r_inflight <= 1'b1;
      r_ifl_pc   <= w_redirect_addr;
      r_ifl_odd  <= redirect_pc[2];
    end else if (stall) begin
      r_inflight <= 1'b0;
    end else begin
      r_pc       <= r_pc + LS_ADDR_W'(PAIR_BYTES);
      r_inflight <= 1'b1;
      r_ifl_pc   <= r_pc;
      r_ifl_odd  <= 1'b0;
    end
  end

  // Presentation: held pair wins over the live read; reset and redirect force a bubble.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_shown       = BUBBLE_PAIR;
    w_shown_valid = 1'b0;
    if (!reset && !redirect) begin
      if (w_hold_valid) begin
        w_shown       = w_hold_pair;
        w_shown_valid = 1'b1;
      end else if (r_inflight) begin
        w_shown       = w_ifl_pair;
        w_shown_valid = 1'b1;
      end
    end
  end

  assign instruction1_IF = w_shown.odd_start ? BUBBLE_INSTR : w_shown.even;
  assign instruction2_IF = w_shown.odd;
  assign pc_IF           = LS_ADDR_W'(w_shown.pc);
  assign fetch_valid     = w_shown_valid;

endmodule

// File: tb/tb_spu_fetch_unit.sv
// Self-checking bench for spu_fetch_unit: a local-store model answers reads and a
// "next pair to offer" reference model predicts every output on every cycle.
module tb_spu_fetch_unit;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         stall = 1'b0;
  logic         redirect = 1'b0;
  logic [W-1:0] redirect_pc = '0;
  logic         ls_rd_en;
  logic [W-1:0] ls_addr;
  logic [63:0]  ls_rdata = '0;
  logic [31:0]  instruction1_IF;
  logic [31:0]  instruction2_IF;
  logic [W-1:0] pc_IF;
  logic         fetch_valid;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the pair to be offered next cycle and the next sequential address.
  logic         m_pend_v   = 1'b0;
  logic [W-1:0] m_pend_pc  = '0;
  logic         m_pend_odd = 1'b0;
  logic [W-1:0] m_next_pc  = '0;

  // Local-store model: remembers last cycle's request.
  logic         mreq_v    = 1'b0;
  logic [W-1:0] mreq_addr = '0;

  always #5 clk = ~clk;

  spu_fetch_unit #(.LS_ADDR_W(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .ls_rd_en        (ls_rd_en),
    .ls_addr         (ls_addr),
    .ls_rdata        (ls_rdata),
    .instruction1_IF (instruction1_IF),
    .instruction2_IF (instruction2_IF),
    .pc_IF           (pc_IF),
    .fetch_valid     (fetch_valid)
  );

  function automatic logic [31:0] word_at(input logic [W-1:0] a);
    return {8'h5A, 6'h00, a};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // One clock cycle: drive inputs, compare all outputs with the model, then advance the model.
  task automatic step(input logic rst, input logic st, input logic rd, input logic [W-1:0] rpc);
    logic [W-1:0] a4;
    logic         exp_v;
    logic         exp_rd;
    logic [W-1:0] exp_addr;
    @(posedge clk);
    #1;
    reset       = rst;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    a4          = mreq_addr + W'(4);
    ls_rdata    = mreq_v ? {word_at(mreq_addr), word_at(a4)} : {$urandom, $urandom};
    @(negedge clk);

    exp_v    = !rst && !rd && m_pend_v;
    exp_rd   = !rst && (rd || !st);
    exp_addr = rd ? {rpc[W-1:3], 3'b000} : m_next_pc;
    a4       = m_pend_pc + W'(4);
    check("fetch_valid", fetch_valid, exp_v);
    check("pc_IF", pc_IF, exp_v ? m_pend_pc : '0);
    check("instruction1_IF", instruction1_IF, (exp_v && !m_pend_odd) ? word_at(m_pend_pc) : 32'h0);
    check("instruction2_IF", instruction2_IF, exp_v ? word_at(a4) : 32'h0);
    check("ls_rd_en", ls_rd_en, exp_rd);
    if (exp_rd) check("ls_addr", ls_addr, exp_addr);

    mreq_v    = ls_rd_en;
    mreq_addr = ls_addr;

    if (rst) begin
      m_pend_v  = 1'b0;
      m_next_pc = '0;
    end else if (rd) begin
      m_pend_v   = 1'b1;
      m_pend_pc  = exp_addr;
      m_pend_odd = rpc[2];
      m_next_pc  = exp_addr + W'(8);
    end else if (!st) begin
      m_pend_v   = 1'b1;
      m_pend_pc  = m_next_pc;
      m_pend_odd = 1'b0;
      m_next_pc  = m_next_pc + W'(8);
    end
  endtask

  initial begin
    logic         r_st;
    logic         r_rd;
    logic         r_rst;
    logic [W-1:0] r_pc;

    repeat (3) step(1'b1, 1'b0, 1'b0, '0);
    check("reset fetch_valid", fetch_valid, 1'b0);
    check("reset ls_rd_en", ls_rd_en, 1'b0);

    // Sequential fetch from 0 up to the request of 0x40.
    step(1'b0, 1'b0, 1'b0, '0);
    check("first req addr", ls_addr, 18'h0);
    check("first cycle bubble", fetch_valid, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0);
    check("pair0 pc", pc_IF, 18'h0);
    check("pair0 even", instruction1_IF, 32'h5A000000);
    check("pair0 odd", instruction2_IF, 32'h5A000004);
    repeat (7) step(1'b0, 1'b0, 1'b0, '0);
    check("req 0x40", ls_addr, 18'h40);

    // Stall three cycles: pair 0x40 frozen, then released without gap or duplicate.
    repeat (3) begin
      step(1'b0, 1'b1, 1'b0, '0);
      check("stall frozen pc", pc_IF, 18'h40);
      check("stall no read", ls_rd_en, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, '0);
    check("release shows 0x40", pc_IF, 18'h40);
    check("release req 0x48", ls_addr, 18'h48);
    step(1'b0, 1'b0, 1'b0, '0);
    check("after release 0x48", pc_IF, 18'h48);

    // Redirect into the odd slot.
    step(1'b0, 1'b0, 1'b1, 18'h104);
    check("redirect bubble", fetch_valid, 1'b0);
    check("redirect addr", ls_addr, 18'h100);
    step(1'b0, 1'b0, 1'b0, '0);
    check("odd start pc", pc_IF, 18'h100);
    check("odd start slot1", instruction1_IF, 32'h0);
    check("odd start slot2", instruction2_IF, 32'h5A000104);
    step(1'b0, 1'b0, 1'b0, '0);
    check("after odd start", pc_IF, 18'h108);

    // Build a held pair, then redirect under stall.
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("held pair", pc_IF, 18'h110);
    step(1'b0, 1'b1, 1'b1, 18'h2000);
    check("redirect under stall addr", ls_addr, 18'h2000);
    check("redirect under stall bubble", fetch_valid, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("target shown", pc_IF, 18'h2000);
    step(1'b0, 1'b1, 1'b0, '0);
    check("target held", pc_IF, 18'h2000);
    step(1'b0, 1'b0, 1'b0, '0);
    check("target released", pc_IF, 18'h2000);

    // Wrap at the top of local store, then reset mid-stream.
    step(1'b0, 1'b0, 1'b1, 18'h3FFF0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    check("wrap addr", ls_addr, 18'h0);
    step(1'b0, 1'b0, 1'b0, '0);
    check("wrapped pair", pc_IF, 18'h0);
    step(1'b1, 1'b0, 1'b0, '0);
    check("reset mid bubble", fetch_valid, 1'b0);
    check("reset mid instr2", instruction2_IF, 32'h0);
    step(1'b0, 1'b0, 1'b0, '0);
    check("refetch addr", ls_addr, 18'h0);
    check("refetch bubble", fetch_valid, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0);
    check("refetch pair0", pc_IF, 18'h0);

    // Random stall/redirect/reset traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r_st  = ($urandom_range(0, 9) < 4);
      r_rd  = ($urandom_range(0, 99) < 7);
      r_rst = ($urandom_range(0, 299) == 0);
      r_pc  = W'($urandom);
      if ($urandom_range(0, 3) == 0) r_pc[W-1:5] = '1;
      step(r_rst, r_st, r_rd, r_pc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
